div_result_buffer: RTL and testbench
====================================

DIV_RESULT_BUFFER -- requirements
Module: div_result_buffer

Interface
REQ-001 The block SHALL have parameter tamanyo, default 32, giving the width of the quotient and remainder.
REQ-002 The block SHALL have parameter PROF, default 8, giving the FIFO depth; it is a power of two and at least 2.
REQ-003 Port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port RSTa, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port Issue, input, 1 bit: pulse marking that upstream has driven Start into the pipelined divider this cycle.
REQ-006 Port Can_Issue, output, 1 bit: high when a credit is available for a new divide.
REQ-007 Port Done, input, 1 bit: result-valid strobe from the divider output stage.
REQ-008 Ports Coc and Res, inputs, tamanyo bits each: quotient and remainder from the divider, valid when Done=1.
REQ-009 Port Out_Valid, output, 1 bit: the FIFO head holds a result.
REQ-010 Port Out_Ready, input, 1 bit: the consumer accepts the head result.
REQ-011 Ports Out_Coc and Out_Res, outputs, tamanyo bits each: the FIFO head result.
REQ-012 Port Count, output, $clog2(PROF)+1 bits: number of results stored in the FIFO.
REQ-013 Port Overflow, output, 1 bit: sticky error flag (see Configuration).

Function
REQ-014 The block SHALL store {Coc,Res} in a PROF-entry circular FIFO with wrapping read and write pointers.
REQ-015 A push SHALL occur on a cycle with Done=1 when the FIFO is not full, or when it is full and a pop happens in the same cycle.
REQ-016 A pop SHALL occur on a cycle with Out_Valid=1 and Out_Ready=1.
REQ-017 Out_Valid SHALL equal (Count!=0), and Out_Coc/Out_Res SHALL show the head entry (first-word fall-through).
REQ-018 A result pushed at edge t SHALL be visible on Out_* with Out_Valid=1 after that edge, i.e. one cycle of latency from Done.
REQ-019 A simultaneous push and pop SHALL leave Count unchanged; on an empty FIFO this is not a pass-through, and Out_Valid rises on the next cycle.
REQ-020 Out_* SHALL hold stable while Out_Valid=1 and Out_Ready=0.
REQ-021 A credit counter Cred, reset to PROF, SHALL track PROF minus (results in flight plus results stored).
REQ-022 Can_Issue SHALL equal (Cred!=0).
REQ-023 An accepted issue is a cycle with Issue=1 and Can_Issue=1; it SHALL decrement Cred.
REQ-024 A pop SHALL increment Cred.
REQ-025 A simultaneous accepted issue and pop SHALL leave Cred unchanged.
REQ-026 Issue while Can_Issue=0 SHALL be ignored by Cred.
REQ-027 Done while the FIFO is full and no pop occurs SHALL drop the result, leave FIFO contents unchanged, and set Overflow when it is enabled.
REQ-028 Cred SHALL never exceed PROF nor drop below 0; Count SHALL never exceed PROF.

Reset
REQ-029 Asserting RSTa SHALL immediately clear both pointers, Count=0, Out_Valid=0, Out_Coc=0, Out_Res=0, Cred=PROF, Can_Issue=1 and Overflow=0.
REQ-030 Reset mid-operation SHALL discard stored and in-flight results; Done pulses after release SHALL be treated as new pushes.
REQ-031 FIFO storage contents need no reset, but Out_* SHALL read 0 while the FIFO is empty.

Configuration
REQ-032 Macro DIV_BUF_OVF_FLAG_EN defined: Overflow SHALL be a sticky register, set by a dropped push and cleared only by RSTa.
REQ-033 Macro DIV_BUF_OVF_FLAG_EN undefined: Overflow SHALL be tied to 0, no flag register SHALL be built, and dropping per REQ-027 still applies.

Verification
REQ-034 Reset, then one Done with Coc=14, Res=2 (100/7) -> Out_Valid=1 one cycle later with Out_Coc=14, Out_Res=2, Count=1; Out_Ready=1 -> Count=0.
REQ-035 PROF=8, Issue held high for 10 cycles, no pops -> Can_Issue falls after 8 accepted issues; Cred=0; the 2 extra Issue pulses are ignored.
REQ-036 Push 8 results (Coc=1..8), Out_Ready=0 -> Count=8 and Out_Coc=1 held; then Out_Ready=1 -> results emerge in order 1..8, one per cycle.
REQ-037 FIFO full plus Done with Coc=9 plus Out_Ready=1 in the same cycle -> Count stays 8, head advances to 2, Coc=9 stored last, Overflow=0.
REQ-038 FIFO full, Done with Coc=9, Out_Ready=0 -> 9 dropped, Count=8; Overflow=1 with the macro, 0 without it.
REQ-039 RSTa asserted with Count=5 and Cred=0 -> asynchronously Count=0, Out_Valid=0, Can_Issue=1, Overflow=0.

Source files
------------

// File: rtl/div_result_buffer_if.sv
// Handshake bundle between the pipelined divider, its issue logic and the result consumer.
// Latency: none (wires only).
// Backpressure: credit on the issue side (Can_Issue), valid/ready on the result side.
interface div_result_buffer_if #(
    parameter int tamanyo = 32,
    parameter int PROF    = 8
);
    localparam int CW = $clog2(PROF) + 1;

    logic               Issue;
    logic               Can_Issue;
    logic               Done;
    logic [tamanyo-1:0] Coc;
    logic [tamanyo-1:0] Res;
    logic               Out_Valid;
    logic               Out_Ready;
    logic [tamanyo-1:0] Out_Coc;
    logic [tamanyo-1:0] Out_Res;
    logic [CW-1:0]      Count;
    logic               Overflow;

    // Upstream issue logic, divider and consumer side.
    modport master (
        output Issue, Done, Coc, Res, Out_Ready,
        input  Can_Issue, Out_Valid, Out_Coc, Out_Res, Count, Overflow
    );

    // The result buffer itself.
    modport slave (
        input  Issue, Done, Coc, Res, Out_Ready,
        output Can_Issue, Out_Valid, Out_Coc, Out_Res, Count, Overflow
    );
endinterface

// File: rtl/div_result_buffer.sv
// Credit-managed result FIFO behind a pipelined divider; holds {Coc,Res} pairs, first-word fall-through.
// Latency: a result pushed on a Done edge is visible on Out_* right after that edge (1 cycle, no pass-through).
// Backpressure: Out_Ready stalls the head; Can_Issue withholds credits; Done into a full FIFO without a pop is dropped.
// Optional feature: define DIV_BUF_OVF_FLAG_EN to build the sticky Overflow register (otherwise Overflow=0).
module div_result_buffer #(
    parameter int tamanyo = 32,
    parameter int PROF    = 8
) (
    input  logic              CLK,
    input  logic              RSTa,
    div_result_buffer_if.slave bus
);
    localparam int AW = $clog2(PROF);
    localparam int CW = AW + 1;
    localparam int DW = 2 * tamanyo;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] cred_q, cred_d;
    logic [DW-1:0] mem_q [PROF];
    logic [DW-1:0] head_dat;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic drop;
    logic iss_acc;

    // Handshake decode: a full FIFO still accepts Done when the head leaves in the same cycle.
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CW'(PROF));
        pop     = !empty && bus.Out_Ready;
        push    = bus.Done && (!full || pop);
        drop    = bus.Done && full && !pop;
        iss_acc = bus.Issue && (cred_q != '0);
    end

    // Next-state for pointers, occupancy and credits; credits saturate at PROF
    // so a Done that arrived without a matching issue cannot inflate them.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cred_d   = cred_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (iss_acc && !pop) begin
            cred_d = cred_q - CW'(1);
        end else if (pop && !iss_acc && (cred_q != CW'(PROF))) begin
            cred_d = cred_q + CW'(1);
        end
    end

    // Control state register; reset discards everything stored or in flight.
    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cred_q   <= CW'(PROF);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cred_q   <= cred_d;
        end
    end

    // Result storage; contents are don't-care until written, outputs mask them when empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.Coc, bus.Res};
        end
    end

    assign head_dat      = mem_q[rd_ptr_q];
    assign bus.Out_Valid = !empty;
    assign bus.Out_Coc   = empty ? '0 : head_dat[DW-1:tamanyo];
    assign bus.Out_Res   = empty ? '0 : head_dat[tamanyo-1:0];
    assign bus.Count     = count_q;
    assign bus.Can_Issue = (cred_q != '0);

`ifdef DIV_BUF_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    // Sticky drop flag, cleared only by reset.
    always_comb begin
        ovf_d = ovf_q | drop;
    end

    // Overflow flag register.
    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.Overflow = ovf_q;
`else
    logic unused_drop;
    assign unused_drop  = drop;
    assign bus.Overflow = 1'b0;
`endif
endmodule

// File: tb/tb_div_result_buffer.sv
// Self-checking bench for div_result_buffer: queue-based reference model plus directed literal checks.
module tb_div_result_buffer;
    localparam int W    = 32;
    localparam int PROF = 8;
`ifdef DIV_BUF_OVF_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic CLK;
    logic RSTa;
    int   total;
    int   bad;
    bit   cmp_en;

    div_result_buffer_if #(.tamanyo(W), .PROF(PROF)) bus ();

    div_result_buffer #(.tamanyo(W), .PROF(PROF)) dut (
        .CLK  (CLK),
        .RSTa (RSTa),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: a queue of {coc,res}, a saturating credit count and a sticky flag.
    logic [2*W-1:0] q[$];
    int             m_cred;
    bit             m_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge CLK or posedge RSTa) begin
        int  n;
        bit  m_pop;
        bit  m_push;
        bit  m_iss;
        if (RSTa) begin
            q.delete();
            m_cred = PROF;
            m_ovf  = 1'b0;
        end else begin
            n      = q.size();
            m_pop  = (n > 0) && bus.Out_Ready;
            m_push = bus.Done && ((n < PROF) || m_pop);
            m_iss  = bus.Issue && (m_cred > 0);
            if (bus.Done && !m_push && OVF_EN) m_ovf = 1'b1;
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back({bus.Coc, bus.Res});
            m_cred = m_cred - int'(m_iss) + int'(m_pop);
            if (m_cred > PROF) m_cred = PROF;
        end
    end

    // Compare process: every settled cycle outside reset, DUT outputs must match the model.
    always @(negedge CLK) begin
        logic [2*W-1:0] hd;
        if (cmp_en && !RSTa) begin
            hd = (q.size() != 0) ? q[0] : '0;
            chk("model_valid", 64'(bus.Out_Valid), 64'(q.size() != 0));
            chk("model_coc",   64'(bus.Out_Coc),   64'(hd[2*W-1:W]));
            chk("model_res",   64'(bus.Out_Res),   64'(hd[W-1:0]));
            chk("model_count", 64'(bus.Count),     64'(q.size()));
            chk("model_cani",  64'(bus.Can_Issue), 64'(m_cred != 0));
            chk("model_ovf",   64'(bus.Overflow),  64'(m_ovf));
        end
    end

    // Drive one cycle of inputs right after a falling edge, return on the next falling edge.
    task automatic step(input logic iss, input logic done, input logic rdy,
                        input logic [W-1:0] c, input logic [W-1:0] r);
        bus.Issue     = iss;
        bus.Done      = done;
        bus.Out_Ready = rdy;
        bus.Coc       = c;
        bus.Res       = r;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RSTa = 1'b1;
        bus.Issue = 1'b0; bus.Done = 1'b0; bus.Out_Ready = 1'b0;
        bus.Coc = '0; bus.Res = '0;
        @(negedge CLK);
        chk("rst_count", 64'(bus.Count), 64'd0);
        chk("rst_cani",  64'(bus.Can_Issue), 64'd1);
        RSTa = 1'b0;
    endtask

    task automatic fill8();
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, W'(i), W'(i + 100));
    endtask

    initial begin
        int acc;
        int pct;
        total = 0; bad = 0; cmp_en = 1'b1;
        RSTa = 1'b1;
        bus.Issue = 1'b0; bus.Done = 1'b0; bus.Out_Ready = 1'b0;
        bus.Coc = '0; bus.Res = '0;
        #1;
        chk("init_valid", 64'(bus.Out_Valid), 64'd0);
        chk("init_ovf",   64'(bus.Overflow),  64'd0);
        chk("init_coc",   64'(bus.Out_Coc),   64'd0);
        @(negedge CLK);
        do_reset();

        // Single result 100/7.
        step(1'b0, 1'b1, 1'b0, 32'd14, 32'd2);
        chk("one_valid", 64'(bus.Out_Valid), 64'd1);
        chk("one_coc",   64'(bus.Out_Coc),   64'd14);
        chk("one_res",   64'(bus.Out_Res),   64'd2);
        chk("one_count", 64'(bus.Count),     64'd1);
        step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        chk("one_popped", 64'(bus.Count), 64'd0);
        chk("one_zero",   64'(bus.Out_Coc), 64'd0);

        // Credits: 10 issues, only 8 accepted.
        do_reset();
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.Can_Issue) acc++;
            step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("cred_acc",  64'(acc), 64'd8);
        chk("cred_zero", 64'(bus.Can_Issue), 64'd0);

        // Fill, hold, drain in order.
        do_reset();
        fill8();
        chk("fill_count", 64'(bus.Count), 64'd8);
        chk("fill_head",  64'(bus.Out_Coc), 64'd1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("hold_head",  64'(bus.Out_Coc), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_coc", 64'(bus.Out_Coc), 64'(i));
            chk("drain_res", 64'(bus.Out_Res), 64'(i + 100));
            step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        end
        chk("drain_empty", 64'(bus.Out_Valid), 64'd0);

        // Full plus push plus pop.
        fill8();
        step(1'b0, 1'b1, 1'b1, 32'd9, 32'd109);
        chk("pp_count", 64'(bus.Count), 64'd8);
        chk("pp_head",  64'(bus.Out_Coc), 64'd2);
        chk("pp_ovf",   64'(bus.Overflow), 64'd0);
        for (int i = 2; i <= 9; i++) begin
            chk("pp_order", 64'(bus.Out_Coc), 64'(i));
            step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        end

        // Full, push without pop: dropped.
        do_reset();
        fill8();
        step(1'b0, 1'b1, 1'b0, 32'd9, 32'd109);
        chk("drop_count", 64'(bus.Count), 64'd8);
        chk("drop_ovf",   64'(bus.Overflow), 64'(OVF_EN));
        for (int i = 1; i <= 8; i++) begin
            chk("drop_order", 64'(bus.Out_Coc), 64'(i));
            step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        end
        chk("drop_empty", 64'(bus.Count), 64'd0);

        // Asynchronous reset with Count=5 and no credits.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, (i < 5), 1'b0, W'(i + 50), W'(i));
        chk("pre_count", 64'(bus.Count), 64'd5);
        chk("pre_cani",  64'(bus.Can_Issue), 64'd0);
        @(posedge CLK);
        #2 RSTa = 1'b1;
        #1;
        chk("arst_count", 64'(bus.Count), 64'd0);
        chk("arst_valid", 64'(bus.Out_Valid), 64'd0);
        chk("arst_cani",  64'(bus.Can_Issue), 64'd1);
        chk("arst_ovf",   64'(bus.Overflow), 64'd0);
        chk("arst_coc",   64'(bus.Out_Coc), 64'd0);
        @(negedge CLK);
        RSTa = 1'b0;
        step(1'b0, 1'b1, 1'b0, 32'd77, 32'd7);
        chk("post_coc",   64'(bus.Out_Coc), 64'd77);
        chk("post_count", 64'(bus.Count), 64'd1);

        // Random traffic with varying consumer throughput and occasional mid-cycle resets.
        pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: pct = 10;
                    1: pct = 50;
                    default: pct = 90;
                endcase
            end
            if (c % 700 == 699) begin
                @(posedge CLK);
                #2 RSTa = 1'b1;
                #2 RSTa = 1'b0;
                @(negedge CLK);
            end
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 99) < pct), W'($urandom), W'($urandom));
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
